// File: rtl/lm32_trace_pkg.sv
// Shared types and widths for the LM32 retire-trace controller.
// LM32_TRACE_TIMESTAMP_EN selects the 52-bit entry that carries a 16-bit timestamp.
package lm32_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  localparam int PC_W       = 30;
  localparam int OPC_W      = 6;
  localparam int TS_W       = 16;
  localparam int ENTRY_W_TS = TS_W + PC_W + OPC_W;
  localparam int ENTRY_W_NO = PC_W + OPC_W;

`ifdef LM32_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = ENTRY_W_TS;
`else
  localparam int ENTRY_W = ENTRY_W_NO;
`endif

endpackage

// File: rtl/lm32_trace_ctrl_if.sv
// W-stage retire stream in, buffered trace entries out (valid/ready).
interface lm32_trace_ctrl_if;
  import lm32_trace_pkg::*;

  logic               valid_w;
  logic               kill_w;
  logic [PC_W-1:0]    pc_w;
  logic [OPC_W-1:0]   opcode_w;
  logic               rd_ready_i;
  logic               rd_valid_o;
  logic [ENTRY_W-1:0] rd_data_o;

  modport master (
    output valid_w, kill_w, pc_w, opcode_w, rd_ready_i,
    input  rd_valid_o, rd_data_o
  );

  modport slave (
    input  valid_w, kill_w, pc_w, opcode_w, rd_ready_i,
    output rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/lm32_trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
module lm32_trace_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 36
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/lm32_trace_ctrl.sv
// Circular retire-trace buffer with PC trigger, post-trigger window and drain readout.
// Optional LM32_TRACE_TIMESTAMP_EN adds a saturating 16-bit cycle stamp per entry.
module lm32_trace_ctrl
  import lm32_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  lm32_trace_ctrl_if.slave bus,
  input  logic             arm_i,
  input  logic             trig_en_i,
  input  logic [PC_W-1:0]  trig_pc_i,
  input  logic [AW-1:0]    post_cnt_i,
  output logic [AW:0]      count_o,
  output logic [1:0]       state_o,
  output logic             wrap_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  trace_state_t       r_state;
  logic [AW:0]        r_count;
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [AW-1:0]      r_post;
  logic               r_wrap;

  logic               w_retire;
  logic               w_cap;
  logic               w_full;
  logic               w_pop;
  logic               w_hit;
  logic [ENTRY_W-1:0] w_wr_data;

  assign w_retire = bus.valid_w & ~bus.kill_w;
  // The arm cycle itself never captures, even though the old state may still be ARMED.
  assign w_cap    = w_retire & ~arm_i & ((r_state == ST_ARMED) | (r_state == ST_POST));
  assign w_full   = (r_count == CNT_FULL);
  assign w_pop    = bus.rd_valid_o & bus.rd_ready_i;
  assign w_hit    = trig_en_i & (bus.pc_w == trig_pc_i);

`ifdef LM32_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] w_ts_stamp;

  // Stamp counts cycles since the arm cycle, so a retire N cycles later reads N.
  assign w_ts_stamp = (r_ts == {TS_W{1'b1}}) ? r_ts : r_ts + TS_W'(1);
  assign w_wr_data  = {w_ts_stamp, bus.pc_w, bus.opcode_w};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ts <= '0;
    end else if (arm_i) begin
      r_ts <= '0;
    end else begin
      r_ts <= w_ts_stamp;
    end
  end
`else
  assign w_wr_data = {bus.pc_w, bus.opcode_w};
`endif

  lm32_trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_cap),
    .waddr_i (r_wp),
    .wdata_i (w_wr_data),
    .raddr_i (r_rp),
    .rdata_o (bus.rd_data_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_post  <= '0;
      r_wrap  <= 1'b0;
    end else if (arm_i) begin
      r_state <= ST_ARMED;
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_post  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      if (w_cap) begin
        r_wp <= r_wp + PTR_ONE;
        if (w_full) begin
          r_rp   <= r_rp + PTR_ONE;
          r_wrap <= 1'b1;
        end else begin
          r_count <= r_count + CNT_ONE;
        end
      end
      case (r_state)
        ST_ARMED: begin
          if (w_retire && w_hit) begin
            r_post  <= post_cnt_i;
            r_state <= (post_cnt_i == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (w_retire) begin
            r_post <= r_post - PTR_ONE;
            if (r_post == PTR_ONE) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (r_count == '0) begin
            r_state <= ST_IDLE;
          end else if (w_pop) begin
            r_rp    <= r_rp + PTR_ONE;
            r_count <= r_count - CNT_ONE;
            if (r_count == CNT_ONE) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_valid_o = (r_state == ST_DONE) && (r_count != '0);
  assign count_o        = r_count;
  assign state_o        = r_state;
  assign wrap_o         = r_wrap;

endmodule

// File: tb/tb_lm32_trace_ctrl.sv
// Scoreboard bench for lm32_trace_ctrl: directed traces, expected pops queued, monitor compares.
module tb_lm32_trace_ctrl;
  import lm32_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic              trig_en = 1'b0;
  logic [29:0]       trig_pc = '0;
  logic [AW-1:0]     post_cnt = '0;
  logic [AW:0]       count;
  logic [1:0]        state;
  logic              wrap;

  int n_pass  = 0;
  int n_total = 0;
  logic [35:0] exp_q[$];

  lm32_trace_ctrl_if bus();

  lm32_trace_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus),
    .arm_i      (arm),
    .trig_en_i  (trig_en),
    .trig_pc_i  (trig_pc),
    .post_cnt_i (post_cnt),
    .count_o    (count),
    .state_o    (state),
    .wrap_o     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] op_of(input logic [29:0] pc);
    return pc[5:0] ^ 6'h15;
  endfunction

  function automatic logic [35:0] ent(input logic [29:0] pc);
    return {pc, op_of(pc)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted read is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid_o && bus.rd_ready_i) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 64'(bus.rd_data_o[35:0]), 64'hDEAD);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        $display("pop pc=0x%0h exp=0x%0h", bus.rd_data_o[35:6], e[35:6]);
        check("rd_data", 64'(bus.rd_data_o[35:0]), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [29:0] tpc, input logic [AW-1:0] pc_n, input logic ten);
    trig_pc  = tpc;
    post_cnt = pc_n;
    trig_en  = ten;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic retire(input logic [29:0] pc, input logic kill);
    bus.valid_w  = 1'b1;
    bus.kill_w   = kill;
    bus.pc_w     = pc;
    bus.opcode_w = op_of(pc);
    tick();
    bus.valid_w = 1'b0;
    bus.kill_w  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.rd_ready_i = 1'b1;
    while (state != 2'd0 && k < 64) begin
      tick();
      k++;
    end
    bus.rd_ready_i = 1'b0;
    check("drain_idle", 64'(state), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [51:0] d0;
    bus.valid_w = 1'b0;
    bus.kill_w = 1'b0;
    bus.pc_w = '0;
    bus.opcode_w = '0;
    bus.rd_ready_i = 1'b0;
    #12;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_wrap", 64'(wrap), 64'd0);
    check("rst_valid", 64'(bus.rd_valid_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Trace 1: trigger mid-stream, two post retires.
    do_arm(30'h102, 4'd2, 1'b1);
    check("armed", 64'(state), 64'd1);
    for (int i = 0; i < 5; i++) begin
      retire(30'h100 + 30'(i), 1'b0);
      exp_q.push_back(ent(30'h100 + 30'(i)));
      if (i == 2) check("t1_post", 64'(state), 64'd2);
    end
    check("t1_done", 64'(state), 64'd3);
    check("t1_count", 64'(count), 64'd5);
    check("t1_wrap", 64'(wrap), 64'd0);
    drain();

    // Trace 2: 20 retires into 16 entries, trigger on the last.
    do_arm(30'h13, 4'd0, 1'b1);
    for (int i = 0; i < 20; i++) retire(30'(i), 1'b0);
    for (int i = 4; i < 20; i++) exp_q.push_back(ent(30'(i)));
    check("t2_done", 64'(state), 64'd3);
    check("t2_count", 64'(count), 64'd16);
    check("t2_wrap", 64'(wrap), 64'd1);
    drain();

    // Trace 3: killed retires are not captured.
    do_arm(30'h204, 4'd0, 1'b1);
    retire(30'h200, 1'b0);
    check("t3_cnt1", 64'(count), 64'd1);
    retire(30'h201, 1'b1);
    check("t3_kill_cnt", 64'(count), 64'd1);
    retire(30'h202, 1'b0);
    retire(30'h203, 1'b1);
    retire(30'h204, 1'b0);
    exp_q.push_back(ent(30'h200));
    exp_q.push_back(ent(30'h202));
    exp_q.push_back(ent(30'h204));
    check("t3_count", 64'(count), 64'd3);
    drain();

    // Trace 4: back-pressure holds the head entry, then one pop per ready cycle.
    do_arm(30'h302, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      retire(30'h300 + 30'(i), 1'b0);
      exp_q.push_back(ent(30'h300 + 30'(i)));
    end
    d0 = 52'(bus.rd_data_o);
    check("t4_head", 64'(d0[35:0]), 64'(ent(30'h300)));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_valid", 64'(bus.rd_valid_o), 64'd1);
      check("t4_hold_data", 64'(bus.rd_data_o), 64'(d0));
    end
    bus.rd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_pop_count", 64'(count), 64'(2 - i));
    end
    bus.rd_ready_i = 1'b0;
    check("t4_idle", 64'(state), 64'd0);
    check("t4_queue", 64'(exp_q.size()), 64'd0);

    // Trace 5: asynchronous reset during POST.
    do_arm(30'h400, 4'd3, 1'b1);
    retire(30'h400, 1'b0);
    check("t5_post", 64'(state), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_state", 64'(state), 64'd0);
    check("t5_rst_count", 64'(count), 64'd0);
    check("t5_rst_valid", 64'(bus.rd_valid_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_after", 64'(state), 64'd0);

`ifdef LM32_TRACE_TIMESTAMP_EN
    // Trace 6: retire three cycles after the arm cycle carries stamp 3.
    do_arm(30'h500, 4'd0, 1'b1);
    tick();
    tick();
    retire(30'h500, 1'b0);
    exp_q.push_back(ent(30'h500));
    check("t6_ts", 64'(bus.rd_data_o[51:36]), 64'd3);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lm32_trace_ctrl.md
LM32_TRACE_CTRL -- requirements
Module: lm32_trace_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, trace buffer entries; power of two, minimum 4.
REQ-002 SHALL have parameter AW, default 4, log2(DEPTH).
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port valid_w, input, 1, W-stage instruction valid.
REQ-006 SHALL have port kill_w, input, 1, W-stage instruction killed.
REQ-007 SHALL have port pc_w, input, 30, word PC of the W-stage instruction (LM32_PC_RNG).
REQ-008 SHALL have port opcode_w, input, 6, opcode field [31:26] of the W-stage instruction.
REQ-009 SHALL have port arm_i, input, 1, single-cycle pulse that clears the buffer and starts capture.
REQ-010 SHALL have port trig_en_i, input, 1, enables the PC-match trigger.
REQ-011 SHALL have port trig_pc_i, input, 30, trigger word PC.
REQ-012 SHALL have port post_cnt_i, input, AW, retires captured after the trigger entry.
REQ-013 SHALL have port rd_ready_i, input, 1, consumer accepts rd_data_o.
REQ-014 SHALL have port rd_valid_o, output, 1, rd_data_o holds a valid entry.
REQ-015 SHALL have port rd_data_o, output, ENTRY_W, entry {timestamp?, pc, opcode}, oldest first.
REQ-016 SHALL have port count_o, output, AW+1, number of valid entries held.
REQ-017 SHALL have port state_o, output, 2, current FSM state.
REQ-018 SHALL have port wrap_o, output, 1, set when any entry was overwritten since arm.

Function
REQ-019 SHALL define a retire as valid_w=1 and kill_w=0 in the same cycle.
REQ-020 SHALL implement FSM states IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-021 SHALL ignore retires in IDLE and DONE.
REQ-022 SHALL, on arm_i in any state, go to ARMED next cycle with count, write pointer, read pointer and wrap_o cleared; a retire in the arm cycle SHALL NOT be captured.
REQ-023 SHALL, in ARMED, write each retire at the write pointer and increment the pointer modulo DEPTH; count saturates at DEPTH.
REQ-024 SHALL, in ARMED at full count, overwrite the oldest entry on a retire, advance the read pointer and set wrap_o.
REQ-025 SHALL, in ARMED with trig_en_i=1, on a retire with pc_w==trig_pc_i, capture that entry and go to POST with post counter=post_cnt_i; with post_cnt_i=0 it SHALL go directly to DONE.
REQ-026 SHALL, in POST, capture each retire with the same wrap rules and decrement the post counter; the retire that brings it to 0 goes to DONE after being captured.
REQ-027 SHALL, in DONE, drive rd_valid_o=1 when count_o>0, with rd_data_o = entry at the read pointer (combinational read, zero latency).
REQ-028 SHALL, in DONE on rd_valid_o && rd_ready_i, advance the read pointer and decrement count; at count 0 it SHALL go to IDLE.
REQ-029 SHALL hold rd_valid_o=0 outside DONE.
REQ-030 SHALL, with trig_en_i=0, stay in ARMED indefinitely, capturing circularly.

Reset
REQ-031 SHALL, on rst_n_i=0, go to IDLE immediately with count_o=0, wrap_o=0, rd_valid_o=0, all pointers and counters 0; buffer contents need not be cleared.
REQ-032 SHALL abort any capture or readout on reset mid-operation.

Configuration
REQ-033 SHALL, with LM32_TRACE_TIMESTAMP_EN defined, keep a 16-bit cycle counter cleared on arm and saturating at 0xFFFF, stored as rd_data_o[51:36]; ENTRY_W=52.
REQ-034 SHALL, without LM32_TRACE_TIMESTAMP_EN, omit the counter; ENTRY_W=36.

Structure
REQ-035 SHALL place the state encodings and the ENTRY_W constants (both macro variants) in a shared package lm32_trace_pkg.
REQ-036 SHALL use one sub-module, lm32_trace_ram: DEPTH x ENTRY_W, one synchronous write port and one asynchronous read port.

Verification
REQ-037 SHALL check: DEPTH=16, arm, 5 retires PC 0x100..0x104, trigger 0x102, post_cnt=2 -> DONE after 0x104, count=5, reads 0x100..0x104, wrap_o=0.
REQ-038 SHALL check: 20 retires 0x0..0x13, trigger 0x13, post_cnt=0 -> count=16, first read 0x4, wrap_o=1.
REQ-039 SHALL check: retires with kill_w=1 interleaved -> killed entries absent and count unchanged by them.
REQ-040 SHALL check: hold rd_ready_i=0 for 3 cycles in DONE -> rd_data_o stable and rd_valid_o=1; then each ready cycle pops one entry; IDLE after the last.
REQ-041 SHALL check: assert rst_n_i low during POST -> state_o=0, count_o=0 without waiting for a clock edge.
REQ-042 SHALL check, with LM32_TRACE_TIMESTAMP_EN: retire 3 cycles after arm -> timestamp field = 3.
